// File: rtl/mem_responder.sv
// Unified instruction/data memory responder with a fixed number of wait states per access.
// Define MEM_ALIGN_CHECK_EN to flag and suppress accesses whose Addr[1:0] is nonzero.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemAck,
  output logic        MemErr
);

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LastCnt = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q;
  logic          rd_q, wr_q, mis_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          ack_q, err_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          req, idle, accept, enter_ack;
  logic          req_mis;
  logic [AW-1:0] req_idx;
  logic          cur_rd, cur_wr, cur_mis;
  logic [AW-1:0] cur_idx;

  assign req     = MemRead | MemWrite;
  assign idle    = (state_q == StIdle);
  assign accept  = idle & req;
  assign req_idx = Addr[AW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  logic unused_addr;
  assign req_mis     = (Addr[1:0] != 2'b00);
  assign unused_addr = ^Addr[31:AW+2];
`else
  logic unused_addr;
  assign req_mis     = 1'b0;
  assign unused_addr = ^{Addr[31:AW+2], Addr[1:0]};
`endif

  // With zero latency the ACK entry edge is the acceptance edge, so use live inputs in IDLE.
  assign cur_rd    = idle ? MemRead  : rd_q;
  assign cur_wr    = idle ? MemWrite : wr_q;
  assign cur_mis   = idle ? req_mis  : mis_q;
  assign cur_idx   = idle ? req_idx  : idx_q;
  assign enter_ack = (state_d == StAck);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (LATENCY == 0) state_d = StAck;
          else              state_d = StWait;
        end
      end
      StWait:  if (cnt_q == LastCnt) state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      mis_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q   <= 4'd0;
        rd_q    <= MemRead;
        wr_q    <= MemWrite;
        mis_q   <= req_mis;
        idx_q   <= req_idx;
        wdata_q <= WriteData;
      end else if (state_q == StWait) begin
        cnt_q <= cnt_q + 4'd1;
      end
      ack_q <= enter_ack;
      err_q <= enter_ack & ((cur_rd & cur_wr) | cur_mis);
      // Simultaneous read+write is performed as a write, so only pure reads load ReadData.
      if (enter_ack && cur_rd && !cur_wr) begin
        rdata_q <= cur_mis ? 32'h0 : mem[cur_idx];
      end
    end
  end

  // Array is intentionally not reset; a write whose ACK cycle sees reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == StAck) && wr_q && !mis_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign ReadData = rdata_q;
  assign MemAck   = ack_q;
  assign MemErr   = err_q;

endmodule

// File: doc/mem_responder.md
# mem_responder

Unified instruction/data memory responder for the multi-cycle MIPS core. It sits on the far side of the datapath's memory port: it accepts read/write requests (`MemRead`, `MemWrite`, byte address, write data) and answers each with a one-cycle acknowledge after a parameterised number of wait states. The control unit stalls in its memory states until `MemAck`. This gives the core realistic, non-zero-latency memory instead of a combinational array.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words; power of two, 4..65536.
- `LATENCY`, 2: wait cycles between request acceptance and acknowledge; 0..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `MemRead`  in  1  read request level; held by the requester until `MemAck`.
- `MemWrite`  in  1  write request level; held by the requester until `MemAck`.
- `Addr`  in  32  byte address; word index is `Addr[log2(DEPTH_WORDS)+1:2]`.
- `WriteData`  in  32  store data, sampled at acceptance.
- `ReadData`  out  32  registered read data; valid in the `MemAck` cycle and held until the next acknowledge.
- `MemAck`  out  1  one-cycle completion pulse.
- `MemErr`  out  1  error pulse, coincident with `MemAck`.

## Operation
- FSM states:
  - IDLE -> WAIT when `MemRead|MemWrite` is high and `LATENCY>0`.
  - IDLE -> ACK when a request is high and `LATENCY==0`.
  - WAIT -> ACK when the wait counter reaches `LATENCY-1`.
  - ACK -> IDLE unconditionally.
- Acceptance happens only in IDLE. On acceptance the block captures the op, word index and `WriteData`. Later changes to the inputs during WAIT or ACK are ignored.
- Wait counter: 4 bits, cleared on acceptance, incremented each WAIT cycle.
- In ACK:
  - `MemAck=1`.
  - Write: the array word is updated at the end of the ACK cycle. `ReadData` is unchanged.
  - Read: `ReadData` is loaded from the array on the edge entering ACK, so it is valid during the ACK cycle.
- `MemRead` and `MemWrite` both high at acceptance: the request is performed as a write, and `MemErr=1` in its ACK cycle.
- Address range: upper address bits above the word index are ignored, so addresses wrap modulo `4*DEPTH_WORDS` bytes.
- Requester rule: deassert the request in the cycle after `MemAck`. A request still high when the FSM is back in IDLE is accepted as a new transaction.
- Array contents are not reset. Before the first write, read data is whatever the simulator or synthesis initial state provides (X in simulation). Benches preload the array hierarchically.

## Timing
- Request high in IDLE at cycle 0 -> `MemAck` in cycle `LATENCY+1`.
- Back-to-back throughput: one transaction per `LATENCY+2` cycles. ACK is always followed by one IDLE cycle.
- Read-after-write to the same word: the second transaction returns the new data.
- Reset values: state IDLE, counter 0, `MemAck=0`, `MemErr=0`, `ReadData=32'h0`.
- Reset asserted mid-transaction: the transaction is aborted and no ack is produced. A write pending in WAIT is dropped and the array is unchanged. A write in its ACK cycle with reset high is also suppressed.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A request with `Addr[1:0]!=2'b00` completes normally with `MemAck` and `MemErr=1`.
  - A misaligned write is suppressed, leaving the array unchanged.
  - A misaligned read returns `ReadData=32'h0`.
- `MEM_ALIGN_CHECK_EN` undefined:
  - `Addr[1:0]` is ignored and every access is word-aligned by truncation.
  - `MemErr` reflects only the simultaneous read+write case.

## Test plan
- `LATENCY=2`: write `32'hDEADBEEF` to `0x10`, then read `0x10` -> ack at cycle 3 for each transaction; read returns `32'hDEADBEEF`, `MemErr=0`.
- `LATENCY=0`: five back-to-back reads with the request held continuously -> one ack every 2 cycles; `ReadData` follows the preloaded words.
- `DEPTH_WORDS=256`: write `32'h1` to `0x400`, then read `0x0` -> returns `32'h1` (wrap-around).
- `MemRead` and `MemWrite` both high, address `0x20`, data `32'hA5A5A5A5` -> word at `0x20` is written and `MemErr=1` with `MemAck`.
- `reset` pulsed in the WAIT state of a write to `0x8` -> no `MemAck`, word at `0x8` keeps its old value, all outputs 0 the next cycle.
- With `MEM_ALIGN_CHECK_EN`: write to `0x13` -> `MemErr=1` and the array is unchanged. Without the macro: the same write stores to `0x10` with `MemErr=0`.
